mtm_alu_resp_deserializer: RTL and testbench

//  Receiver for the ALU result stream: decodes the 1-bit serial response line (sin) back into
//  32-bit result C and 8-bit CTL. Sits on the consumer side of the ALU output (scoreboard/host

---
 rtl/mtm_alu_pkg.sv | 35 +++
 rtl/mtm_alu_frame_rx.sv | 72 +++++++
 rtl/mtm_alu_resp_deserializer.sv | 120 ++++++++++++
 tb/tb_mtm_alu_resp_deserializer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the MTM ALU serial response link: frame layout,
// error CTL codes, receiver state encoding and response commit actions.
package mtm_alu_pkg;

    localparam int FRAME_LEN = 11;
    localparam int DATA_BITS = FRAME_LEN - 3;

    localparam logic PKT_DATA = 1'b0;
    localparam logic PKT_CTL  = 1'b1;

    localparam logic [7:0] ERR_DATA = 8'hC9;
    localparam logic [7:0] ERR_CRC  = 8'h93;
    localparam logic [7:0] ERR_OP   = 8'hA5;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_PKT,
        RX_DATA,
        RX_STOP,
        RX_RESYNC
    } rx_state_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_STORE,
        ACT_DATA_RESP,
        ACT_ERR_RESP,
        ACT_FRAME_ERR
    } resp_act_t;

    function automatic logic is_err_ctl(input logic [7:0] ctl);
        return (ctl == ERR_DATA) || (ctl == ERR_CRC) || (ctl == ERR_OP);
    endfunction

endpackage

// File: rtl/mtm_alu_frame_rx.sv
// Single-frame receiver: start, pkt bit, 8 data bits MSB first, stop.
// A low stop bit parks the receiver in RESYNC until the line returns high.
module mtm_alu_frame_rx
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    output logic       in_idle,
    output logic       frame_done,
    output logic       stop_err,
    output logic       pkt_type,
    output logic [7:0] rx_byte
);

    rx_state_t  state;
    rx_state_t  state_nxt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_q;
    logic       pkt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RX_IDLE;
            bit_cnt <= '0;
            shift_q <= '0;
            pkt_q   <= PKT_DATA;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
            state <= state_nxt;
            case (state)
                RX_PKT: begin
                    pkt_q   <= sin;
                    bit_cnt <= '0;
                end
                RX_DATA: begin
                    shift_q <= {shift_q[6:0], sin};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_nxt  = state;
        frame_done = 1'b0;
        stop_err   = 1'b0;
        case (state)
            RX_IDLE:   if (!sin) state_nxt = RX_PKT;
            RX_PKT:    state_nxt = RX_DATA;
            RX_DATA:   if (bit_cnt == 3'(DATA_BITS - 1)) state_nxt = RX_STOP;
            RX_STOP: begin
                if (sin) begin
                    frame_done = 1'b1;
                    state_nxt  = RX_IDLE;
                end else begin
                    stop_err  = 1'b1;
                    state_nxt = RX_RESYNC;
                end
            end
            RX_RESYNC: if (sin) state_nxt = RX_IDLE;
            default:   state_nxt = RX_IDLE;
        endcase
    end

    assign in_idle  = (state == RX_IDLE);
    assign pkt_type = pkt_q;
    assign rx_byte  = shift_q;

endmodule

// File: rtl/mtm_alu_resp_deserializer.sv
// ALU response receiver: assembles N data frames plus a CTL frame into C/CTL,
// accepts CTL-only error responses and flags framing/protocol violations.
module mtm_alu_resp_deserializer
    import mtm_alu_pkg::*;
#(
    parameter int N_DATA_BYTES = 4,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sin,
    output logic [8*N_DATA_BYTES-1:0] C_out,
    output logic [7:0]                CTL_out,
    output logic                      out_valid,
    output logic                      err_flag,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int BCW = $clog2(N_DATA_BYTES + 1);
    localparam int TCW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    logic                      rx_idle;
    logic                      rx_done;
    logic                      rx_stop_err;
    logic                      rx_pkt;
    logic [7:0]                rx_byte;

    logic [BCW-1:0]            byte_cnt;
    logic [TCW-1:0]            idle_cnt;
    logic [8*N_DATA_BYTES-1:0] acc;

    resp_act_t                 act;
    logic                      bytes_full;
    logic                      idle_count_en;
    logic                      timeout_hit;

    mtm_alu_frame_rx u_frame_rx (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .in_idle   (rx_idle),
        .frame_done(rx_done),
        .stop_err  (rx_stop_err),
        .pkt_type  (rx_pkt),
        .rx_byte   (rx_byte)
    );

    // Timeout only runs between frames of a response that has already started.
    always_comb begin
        bytes_full    = (byte_cnt == BCW'(N_DATA_BYTES));
        idle_count_en = rx_idle && sin && (byte_cnt != '0);
        timeout_hit   = idle_count_en && (idle_cnt == TCW'(IDLE_TIMEOUT - 1));

        act = ACT_NONE;
        if (rx_stop_err || timeout_hit) begin
            act = ACT_FRAME_ERR;
        end else if (rx_done) begin
            if (rx_pkt == PKT_DATA) begin
                act = bytes_full ? ACT_FRAME_ERR : ACT_STORE;
            end else if (bytes_full && !rx_byte[7]) begin
                act = ACT_DATA_RESP;
            end else if ((byte_cnt == '0) && is_err_ctl(rx_byte)) begin
                act = ACT_ERR_RESP;
            end else begin
                act = ACT_FRAME_ERR;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            C_out     <= '0;
            CTL_out   <= '0;
            out_valid <= 1'b0;
            err_flag  <= 1'b0;
            frame_err <= 1'b0;
            byte_cnt  <= '0;
            idle_cnt  <= '0;
            acc       <= '0;
        end else begin
            out_valid <= 1'b0;
            err_flag  <= 1'b0;
            frame_err <= 1'b0;

            if (!idle_count_en || timeout_hit) idle_cnt <= '0;
            else                               idle_cnt <= idle_cnt + 1'b1;

            case (act)
                ACT_STORE: begin
                    // First byte on the line is the most significant one.
                    for (int i = 0; i < N_DATA_BYTES; i++) begin
                        if (byte_cnt == BCW'(N_DATA_BYTES - 1 - i)) acc[8*i +: 8] <= rx_byte;
                    end
                    byte_cnt <= byte_cnt + 1'b1;
                end
                ACT_DATA_RESP: begin
                    C_out     <= acc;
                    CTL_out   <= rx_byte;
                    out_valid <= 1'b1;
                    byte_cnt  <= '0;
                end
                ACT_ERR_RESP: begin
                    CTL_out   <= rx_byte;
                    out_valid <= 1'b1;
                    err_flag  <= 1'b1;
                    byte_cnt  <= '0;
                end
                ACT_FRAME_ERR: begin
                    frame_err <= 1'b1;
                    byte_cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy = !rx_idle || (byte_cnt != '0);

endmodule

// File: tb/tb_mtm_alu_resp_deserializer.sv
// Self-checking bench: directed cases plus random responses, compared against a
// frame-level protocol model kept as a byte queue.
module tb_mtm_alu_resp_deserializer;

    localparam int N  = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        sin;
    logic [31:0] C_out;
    logic [7:0]  CTL_out;
    logic        out_valid;
    logic        err_flag;
    logic        frame_err;
    logic        busy;

    mtm_alu_resp_deserializer #(.N_DATA_BYTES(N), .IDLE_TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .sin      (sin),
        .C_out    (C_out),
        .CTL_out  (CTL_out),
        .out_valid(out_valid),
        .err_flag (err_flag),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: frame-level protocol rules.
    logic [7:0]  m_q[$];
    logic [31:0] exp_c     = '0;
    logic [7:0]  exp_ctl   = '0;
    logic        exp_err   = 1'b0;
    int          exp_valid = 0;
    int          exp_ferr  = 0;
    int          idle_run  = 0;

    task automatic model_frame(input logic pkt, input logic [7:0] b, input logic stop_ok);
        logic [31:0] c;
        idle_run = 0;
        if (!stop_ok) begin
            exp_ferr++;
            m_q.delete();
        end else if (pkt == 1'b0) begin
            if (m_q.size() < N) begin
                m_q.push_back(b);
            end else begin
                exp_ferr++;
                m_q.delete();
            end
        end else begin
            if (m_q.size() == N && !b[7]) begin
                c = '0;
                foreach (m_q[i]) c = (c << 8) | 32'(m_q[i]);
                exp_c   = c;
                exp_ctl = b;
                exp_err = 1'b0;
                exp_valid++;
            end else if (m_q.size() == 0 && (b == 8'hC9 || b == 8'h93 || b == 8'hA5)) begin
                exp_ctl = b;
                exp_err = 1'b1;
                exp_valid++;
            end else begin
                exp_ferr++;
            end
            m_q.delete();
        end
    endtask

    task automatic model_idle();
        if (m_q.size() != 0) begin
            idle_run++;
            if (idle_run == TO) begin
                exp_ferr++;
                m_q.delete();
                idle_run = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_c    = '0;
        exp_ctl  = '0;
        idle_run = 0;
    endtask

    // Monitor: observed pulses and per-cycle invariants.
    int          act_valid      = 0;
    int          act_ferr       = 0;
    logic        last_err       = 1'b0;
    int unsigned last_valid_cyc = 0;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("excl_valid_ferr", out_valid & frame_err, 0);
            check("err_unqualified", err_flag & ~out_valid, 0);
            if (out_valid === 1'b1) begin
                act_valid++;
                last_err       = err_flag;
                last_valid_cyc = cyc;
            end
            if (frame_err === 1'b1) act_ferr++;
        end
    end

    // Stimulus: inputs change on the falling edge, DUT samples on the rising edge.
    int unsigned frame_start_cyc = 0;
    int unsigned resp_start_cyc  = 0;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) sin = 1'b1;
            model_idle();
        end
    endtask

    task automatic send_frame(input logic pkt, input logic [7:0] b, input logic stop_ok,
                              input int lows);
        @(negedge clk) sin = 1'b0;
        frame_start_cyc = cyc;
        @(negedge clk) sin = pkt;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk) sin = b[i];
        end
        @(negedge clk) sin = stop_ok;
        model_frame(pkt, b, stop_ok);
        if (!stop_ok) begin
            for (int i = 0; i < lows; i++) begin
                @(negedge clk) sin = 1'b0;
            end
            @(negedge clk) sin = 1'b1;
        end
    endtask

    task automatic send_resp(input logic [31:0] c, input logic [7:0] ctl, input int gap);
        for (int i = N - 1; i >= 0; i--) begin
            send_frame(1'b0, c[8*i +: 8], 1'b1, 0);
            if (i == N - 1) resp_start_cyc = frame_start_cyc;
            idle(gap);
        end
        send_frame(1'b1, ctl, 1'b1, 0);
    endtask

    task automatic checkpoint(input string tag);
        idle(2);
        @(negedge clk) sin = 1'b1;
        #1;
        check({tag, ".n_valid"}, act_valid, exp_valid);
        check({tag, ".n_ferr"}, act_ferr, exp_ferr);
        check({tag, ".c_out"}, C_out, exp_c);
        check({tag, ".ctl_out"}, CTL_out, exp_ctl);
        check({tag, ".busy"}, busy, (m_q.size() != 0));
        if (exp_valid > 0) check({tag, ".err_flag"}, last_err, exp_err);
        model_idle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    logic [7:0] err_codes[3] = '{8'hC9, 8'h93, 8'hA5};

    initial begin
        rst = 1'b1;
        sin = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.c_out", C_out, 0);
        check("rst.ctl_out", CTL_out, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.err_flag", err_flag, 0);
        check("rst.frame_err", frame_err, 0);
        check("rst.busy", busy, 0);
        idle(2);

        // 1: back-to-back normal response, latency from first start bit
        send_resp(32'h12345678, 8'h05, 0);
        checkpoint("t1");
        check("t1.latency", last_valid_cyc - resp_start_cyc, 55);

        // 2: CTL-only error response keeps C_out
        send_frame(1'b1, 8'hC9, 1'b1, 0);
        checkpoint("t2");

        // 3: bad stop bit, line held low, then a clean response
        send_frame(1'b0, 8'hAB, 1'b0, 5);
        checkpoint("t3a");
        send_resp(32'hDEADBEEF, 8'h0A, 1);
        checkpoint("t3b");

        // 4: timeout between frames, one cycle short then reached
        send_frame(1'b0, 8'h11, 1'b1, 0);
        send_frame(1'b0, 8'h22, 1'b1, 0);
        idle(TO - 1);
        check("t4.no_early_ferr", act_ferr, exp_ferr);
        check("t4.busy_held", busy, 1);
        idle(1);
        checkpoint("t4a");
        send_resp(32'hCAFEF00D, 8'h33, 2);
        checkpoint("t4b");

        // 5: protocol errors
        send_frame(1'b0, 8'h01, 1'b1, 0);
        send_frame(1'b0, 8'h02, 1'b1, 0);
        send_frame(1'b1, 8'h05, 1'b1, 0);
        checkpoint("t5a");
        for (int i = 0; i < 5; i++) send_frame(1'b0, 8'(8'h40 + i), 1'b1, 0);
        checkpoint("t5b");
        send_frame(1'b1, 8'h05, 1'b1, 0);
        checkpoint("t5c");
        for (int i = 0; i < 4; i++) send_frame(1'b0, 8'(8'h50 + i), 1'b1, 0);
        send_frame(1'b1, 8'hC9, 1'b1, 0);
        checkpoint("t5d");

        // 6: asynchronous reset during bit 4 of the third data frame
        send_frame(1'b0, 8'h11, 1'b1, 0);
        send_frame(1'b0, 8'h22, 1'b1, 0);
        @(negedge clk) sin = 1'b0;
        @(negedge clk) sin = 1'b0;
        for (int i = 7; i >= 3; i--) begin
            @(negedge clk) sin = 1'(8'h33 >> i);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("t6.c_out", C_out, 0);
        check("t6.ctl_out", CTL_out, 0);
        check("t6.out_valid", out_valid, 0);
        check("t6.frame_err", frame_err, 0);
        check("t6.busy", busy, 0);
        @(negedge clk) sin = 1'b1;
        @(negedge clk) rst = 1'b0;
        idle(2);
        send_resp(32'h00000001, 8'h7F, 0);
        checkpoint("t6");

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            int k;
            int gap;
            k   = $urandom_range(0, 99);
            gap = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(0, 3);
            if (k < 55) begin
                send_resp($urandom, 8'($urandom_range(0, 127)), gap);
            end else if (k < 70) begin
                send_frame(1'b1, err_codes[$urandom_range(0, 2)], 1'b1, 0);
            end else begin
                int nf;
                nf = $urandom_range(1, 6);
                for (int f = 0; f < nf; f++) begin
                    send_frame(1'($urandom_range(0, 3) == 0), 8'($urandom),
                               1'($urandom_range(0, 7) != 0), $urandom_range(0, 3));
                    idle((f == nf - 1) ? 0 : gap);
                end
            end
            checkpoint($sformatf("rnd%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
